// File: rtl/tdc_measure_ctrl.sv
// ============================================================================
// tdc_measure_ctrl : carry-chain TDC sequencer, emits one {coarse,fine} stamp per arm.
// Optional calibration statistics enabled with macro TDC_CAL_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module tdc_measure_ctrl #(
  parameter  int THERM_W  = 63,
  parameter  int COARSE_W = 16,
  parameter  int PIPE_LAT = 2,
  parameter  int TIMEOUT  = 1000,
  localparam int FINE_W   = $clog2(THERM_W + 1)
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                arm_i,
  input  logic [THERM_W-1:0]  therm_i,
  input  logic                ts_ready_i,
`ifdef TDC_CAL_EN
  input  logic                cal_clear_i,
  output logic [FINE_W-1:0]   cal_min_o,
  output logic [FINE_W-1:0]   cal_max_o,
  output logic [15:0]         cal_count_o,
`endif
  output logic                trig_en_o,
  output logic                tdc_reset_o,
  output logic                busy_o,
  output logic                ts_valid_o,
  output logic [COARSE_W-1:0] ts_coarse_o,
  output logic [FINE_W-1:0]   ts_fine_o,
  output logic [1:0]          ts_flags_o
);

  localparam int CLR_W = $clog2(PIPE_LAT + 2);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_HOLD, S_CLEAR} state_t;

  state_t              state_q;
  logic [COARSE_W-1:0] cnt_q;
  logic [CLR_W-1:0]    clr_q;
  logic                trig_en_q, tdc_reset_q, busy_q, ts_valid_q;
  logic [COARSE_W-1:0] ts_coarse_q;
  logic [FINE_W-1:0]   ts_fine_q;
  logic [1:0]          ts_flags_q;

  logic [FINE_W-1:0]   pop_d;
  logic                hit_d;
  logic                early_d;

  // Plain popcount rather than leading-one search so bubbles in the code are absorbed.
  always_comb begin
    pop_d = '0;
    for (int i = 0; i < THERM_W; i++) begin
      pop_d = pop_d + FINE_W'(therm_i[i]);
    end
  end

  assign hit_d   = (therm_i != '0);
  assign early_d = (cnt_q < COARSE_W'(PIPE_LAT));

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      clr_q       <= '0;
      trig_en_q   <= 1'b0;
      tdc_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      ts_valid_q  <= 1'b0;
      ts_coarse_q <= '0;
      ts_fine_q   <= '0;
      ts_flags_q  <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm_i) begin
            state_q     <= S_ARMED;
            cnt_q       <= '0;
            trig_en_q   <= 1'b1;
            tdc_reset_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        S_ARMED: begin
          cnt_q <= cnt_q + 1'b1;
          if (hit_d) begin
            state_q    <= S_HOLD;
            trig_en_q  <= 1'b0;
            ts_valid_q <= 1'b1;
            ts_fine_q  <= pop_d;
            if (early_d) begin
              ts_coarse_q <= '0;
              ts_flags_q  <= 2'b10;
            end else begin
              ts_coarse_q <= cnt_q - COARSE_W'(PIPE_LAT);
              ts_flags_q  <= 2'b00;
            end
          end else if (cnt_q == COARSE_W'(TIMEOUT - 1)) begin
            state_q     <= S_HOLD;
            trig_en_q   <= 1'b0;
            ts_valid_q  <= 1'b1;
            ts_coarse_q <= COARSE_W'(TIMEOUT);
            ts_fine_q   <= '0;
            ts_flags_q  <= 2'b01;
          end
        end
        S_HOLD: begin
          if (ts_ready_i) begin
            state_q     <= S_CLEAR;
            ts_valid_q  <= 1'b0;
            tdc_reset_q <= 1'b1;
            clr_q       <= '0;
          end
        end
        S_CLEAR: begin
          // Hold the sample flops in reset long enough to flush both sync stages.
          if (clr_q == CLR_W'(PIPE_LAT)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            clr_q <= clr_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign trig_en_o   = trig_en_q;
  assign tdc_reset_o = tdc_reset_q;
  assign busy_o      = busy_q;
  assign ts_valid_o  = ts_valid_q;
  assign ts_coarse_o = ts_coarse_q;
  assign ts_fine_o   = ts_fine_q;
  assign ts_flags_o  = ts_flags_q;

`ifdef TDC_CAL_EN
  logic [FINE_W-1:0] cal_min_q, cal_max_q;
  logic [15:0]       cal_count_q;

  always_ff @(posedge clock_i) begin
    if (reset_i || cal_clear_i) begin
      cal_min_q   <= '1;
      cal_max_q   <= '0;
      cal_count_q <= '0;
    end else if (state_q == S_ARMED && hit_d && !early_d) begin
      if (pop_d < cal_min_q) cal_min_q <= pop_d;
      if (pop_d > cal_max_q) cal_max_q <= pop_d;
      if (cal_count_q != 16'hFFFF) cal_count_q <= cal_count_q + 16'd1;
    end
  end

  assign cal_min_o   = cal_min_q;
  assign cal_max_o   = cal_max_q;
  assign cal_count_o = cal_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tdc_measure_ctrl.sv
// ============================================================================
// tb_tdc_measure_ctrl : directed self-checking bench for tdc_measure_ctrl.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tdc_measure_ctrl;

  localparam int THERM_W  = 63;
  localparam int COARSE_W = 16;
  localparam int FINE_W   = 6;

  logic                clock_i = 1'b0;
  logic                reset_i, arm_i, ts_ready_i;
  logic [THERM_W-1:0]  therm_i;
  logic                trig_en_o, tdc_reset_o, busy_o, ts_valid_o;
  logic [COARSE_W-1:0] ts_coarse_o;
  logic [FINE_W-1:0]   ts_fine_o;
  logic [1:0]          ts_flags_o;
`ifdef TDC_CAL_EN
  logic                cal_clear_i;
  logic [FINE_W-1:0]   cal_min_o, cal_max_o;
  logic [15:0]         cal_count_o;
`endif

  int tests = 0;
  int fails = 0;

  tdc_measure_ctrl #(.THERM_W(THERM_W), .COARSE_W(COARSE_W), .PIPE_LAT(2), .TIMEOUT(1000)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .arm_i(arm_i), .therm_i(therm_i),
    .ts_ready_i(ts_ready_i),
`ifdef TDC_CAL_EN
    .cal_clear_i(cal_clear_i), .cal_min_o(cal_min_o), .cal_max_o(cal_max_o),
    .cal_count_o(cal_count_o),
`endif
    .trig_en_o(trig_en_o), .tdc_reset_o(tdc_reset_o), .busy_o(busy_o),
    .ts_valid_o(ts_valid_o), .ts_coarse_o(ts_coarse_o), .ts_fine_o(ts_fine_o),
    .ts_flags_o(ts_flags_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ts(input string tag, input logic [15:0] c, input logic [5:0] f,
                        input logic [1:0] fl);
    chk({tag, ".valid"},  {63'd0, ts_valid_o}, 64'd1);
    chk({tag, ".coarse"}, {48'd0, ts_coarse_o}, {48'd0, c});
    chk({tag, ".fine"},   {58'd0, ts_fine_o},   {58'd0, f});
    chk({tag, ".flags"},  {62'd0, ts_flags_o},  {62'd0, fl});
  endtask

  // Arm, keep therm at zero for 'waits' ARMED cycles, then present t for one cycle.
  task automatic measure(input int waits, input logic [THERM_W-1:0] t);
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
    repeat (waits) step();
    therm_i = t;
    step();
    therm_i = '0;
  endtask

  task automatic ack_and_idle(input string tag);
    int n;
    ts_ready_i = 1'b1;
    step();
    ts_ready_i = 1'b0;
    n = 0;
    while (busy_o && n < 20) begin
      step();
      n++;
    end
    chk({tag, ".idle"}, {63'd0, busy_o}, 64'd0);
  endtask

  initial begin
    reset_i    = 1'b1;
    arm_i      = 1'b0;
    ts_ready_i = 1'b0;
    therm_i    = '0;
`ifdef TDC_CAL_EN
    cal_clear_i = 1'b0;
`endif
    step();
    step();
    chk("rst.tdc_reset", {63'd0, tdc_reset_o}, 64'd1);
    chk("rst.trig_en",   {63'd0, trig_en_o},   64'd0);
    chk("rst.busy",      {63'd0, busy_o},      64'd0);
    chk("rst.valid",     {63'd0, ts_valid_o},  64'd0);
    chk("rst.coarse",    {48'd0, ts_coarse_o}, 64'd0);
    chk("rst.fine",      {58'd0, ts_fine_o},   64'd0);
    chk("rst.flags",     {62'd0, ts_flags_o},  64'd0);
    reset_i = 1'b0;
    step();

    // Basic hit: nine empty ARMED cycles, hit on the tenth (cnt=9) -> coarse 7
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
    chk("t1.trig_en", {63'd0, trig_en_o},   64'd1);
    chk("t1.tdc_rst", {63'd0, tdc_reset_o}, 64'd0);
    chk("t1.busy",    {63'd0, busy_o},      64'd1);
    repeat (9) step();
    chk("t1.notyet", {63'd0, ts_valid_o}, 64'd0);
    therm_i = 63'hFF;
    step();
    therm_i = '0;
    chk_ts("t1", 16'd7, 6'd8, 2'b00);
    chk("t1.trig_off", {63'd0, trig_en_o}, 64'd0);
    ack_and_idle("t1");

    // Timeout: 999 quiet cycles still armed, 1000th produces the timeout stamp
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
    repeat (999) step();
    chk("t2.notyet", {63'd0, ts_valid_o}, 64'd0);
    step();
    chk_ts("t2", 16'd1000, 6'd0, 2'b01);
    ack_and_idle("t2");

    // Hit coinciding with the timeout cycle: hit wins
    measure(999, 63'h1);
    chk_ts("t2b", 16'd997, 6'd1, 2'b00);
    ack_and_idle("t2b");

    // Early hit with bubbled code, then first non-early cycle with a full chain
    measure(0, 63'b1011);
    chk_ts("t3", 16'd0, 6'd3, 2'b10);
    ack_and_idle("t3");
    measure(1, 63'h7);
    chk_ts("t3b", 16'd0, 6'd3, 2'b10);
    ack_and_idle("t3b");
    measure(2, {THERM_W{1'b1}});
    chk_ts("t3c", 16'd0, 6'd63, 2'b00);
    ack_and_idle("t3c");

    // Back-pressure, then CLEAR length and an arm dropped mid-CLEAR
    measure(5, 63'h3F);
    repeat (10) begin
      step();
      chk_ts("t4.hold", 16'd3, 6'd6, 2'b00);
    end
    ts_ready_i = 1'b1;
    step();
    ts_ready_i = 1'b0;
    chk("t4.c1.tdc",  {63'd0, tdc_reset_o}, 64'd1);
    chk("t4.c1.busy", {63'd0, busy_o},      64'd1);
    chk("t4.c1.vld",  {63'd0, ts_valid_o},  64'd0);
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
    chk("t4.c2.tdc",  {63'd0, tdc_reset_o}, 64'd1);
    chk("t4.c2.busy", {63'd0, busy_o},      64'd1);
    step();
    chk("t4.c3.tdc",  {63'd0, tdc_reset_o}, 64'd1);
    chk("t4.c3.busy", {63'd0, busy_o},      64'd1);
    step();
    chk("t4.idle.busy", {63'd0, busy_o},    64'd0);
    chk("t4.idle.trig", {63'd0, trig_en_o}, 64'd0);
    ts_ready_i = 1'b1;
    step();
    ts_ready_i = 1'b0;
    step();
    chk("t4.dropped.busy", {63'd0, busy_o},    64'd0);
    chk("t4.dropped.trig", {63'd0, trig_en_o}, 64'd0);
    chk("t4.dropped.vld",  {63'd0, ts_valid_o}, 64'd0);

    // Reset during ARMED and during HOLD
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
    step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    chk("t5a.busy", {63'd0, busy_o},      64'd0);
    chk("t5a.trig", {63'd0, trig_en_o},   64'd0);
    chk("t5a.tdc",  {63'd0, tdc_reset_o}, 64'd1);
    chk("t5a.vld",  {63'd0, ts_valid_o},  64'd0);
    measure(4, 63'h3);
    chk_ts("t5b.pre", 16'd2, 6'd2, 2'b00);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    chk("t5b.busy",   {63'd0, busy_o},      64'd0);
    chk("t5b.trig",   {63'd0, trig_en_o},   64'd0);
    chk("t5b.tdc",    {63'd0, tdc_reset_o}, 64'd1);
    chk("t5b.vld",    {63'd0, ts_valid_o},  64'd0);
    chk("t5b.coarse", {48'd0, ts_coarse_o}, 64'd0);

`ifdef TDC_CAL_EN
    chk("t6.rst.min", {58'd0, cal_min_o},   64'h3F);
    chk("t6.rst.max", {58'd0, cal_max_o},   64'd0);
    chk("t6.rst.cnt", {48'd0, cal_count_o}, 64'd0);
    measure(3, 63'h1F);
    ack_and_idle("t6.a");
    measure(3, (63'h1 << 40) - 63'h1);
    ack_and_idle("t6.b");
    measure(0, 63'h1);
    ack_and_idle("t6.early");
    measure(3, 63'hFFF);
    ack_and_idle("t6.c");
    chk("t6.min", {58'd0, cal_min_o},   64'd5);
    chk("t6.max", {58'd0, cal_max_o},   64'd40);
    chk("t6.cnt", {48'd0, cal_count_o}, 64'd3);
    cal_clear_i = 1'b1;
    step();
    cal_clear_i = 1'b0;
    chk("t6.clr.min", {58'd0, cal_min_o},   64'h3F);
    chk("t6.clr.max", {58'd0, cal_max_o},   64'd0);
    chk("t6.clr.cnt", {48'd0, cal_count_o}, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
